// File: rtl/tri_port_ram_ctrl.sv
// Tri-port RAM controller: arbitrates the L, M and R ports and walks every access
// through a SETUP/STROBE/RELEASE sequence toward an external bit-cell array.
module tri_port_ram_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   L_req,
   input  logic                   L_we,
   input  logic [ADDR_W-1:0]      L_addr,
   input  logic [DATA_W-1:0]      L_wdata,
   output logic                   L_gnt,
   output logic                   L_rvalid,
   output logic [DATA_W-1:0]      L_rdata,
   output logic [(2**ADDR_W)-1:0] LS,
   output logic                   LW,
   output logic [DATA_W-1:0]      LDBL,
   input  logic [DATA_W-1:0]      LDBL_read,
   input  logic                   M_req,
   input  logic                   M_we,
   input  logic [ADDR_W-1:0]      M_addr,
   input  logic [DATA_W-1:0]      M_wdata,
   output logic                   M_gnt,
   output logic                   M_rvalid,
   output logic [DATA_W-1:0]      M_rdata,
   output logic [(2**ADDR_W)-1:0] MS,
   output logic                   MW,
   output logic [DATA_W-1:0]      MDBL,
   input  logic [DATA_W-1:0]      MDBL_read,
   input  logic                   R_req,
   input  logic                   R_we,
   input  logic [ADDR_W-1:0]      R_addr,
   input  logic [DATA_W-1:0]      R_wdata,
   output logic                   R_gnt,
   output logic                   R_rvalid,
   output logic [DATA_W-1:0]      R_rdata,
   output logic [(2**ADDR_W)-1:0] RS,
   output logic                   RW,
   output logic [DATA_W-1:0]      RDBL,
   input  logic [DATA_W-1:0]      RDBL_read
);

   localparam int WORDS = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        req, we, acc;
   logic [ADDR_W-1:0] addr     [3];
   logic [DATA_W-1:0] wdata    [3];
   logic [DATA_W-1:0] dbl_read [3];
   logic [2:0]        act_q, act_d, wr_q, wr_d, pw_q, pw_d, rvalid_q, rvalid_d;
   logic [WORDS-1:0]  sel_q    [3];
   logic [WORDS-1:0]  sel_d    [3];
   logic [DATA_W-1:0] dbl_q    [3];
   logic [DATA_W-1:0] dbl_d    [3];
   logic [DATA_W-1:0] rdata_q  [3];
   logic [DATA_W-1:0] rdata_d  [3];

   // Port index order doubles as write priority: 0 = L, 1 = M, 2 = R.
   assign req         = {R_req, M_req, L_req};
   assign we          = {R_we, M_we, L_we};
   assign addr[0]     = L_addr;
   assign addr[1]     = M_addr;
   assign addr[2]     = R_addr;
   assign wdata[0]    = L_wdata;
   assign wdata[1]    = M_wdata;
   assign wdata[2]    = R_wdata;
   assign dbl_read[0] = LDBL_read;
   assign dbl_read[1] = MDBL_read;
   assign dbl_read[2] = RDBL_read;

   // A write loses only to a higher-priority write of the same word; reads always win.
   always_comb begin
      acc = req;
      if (we[1] && req[0] && we[0] && (addr[0] == addr[1])) acc[1] = 1'b0;
      if (we[2] && ((req[0] && we[0] && (addr[0] == addr[2])) ||
                    (req[1] && we[1] && (addr[1] == addr[2])))) acc[2] = 1'b0;
   end

   always_comb begin
      state_d  = state_q;
      act_d    = act_q;
      wr_d     = wr_q;
      pw_d     = '0;
      rvalid_d = '0;
      sel_d    = sel_q;
      dbl_d    = dbl_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (|acc) begin
               state_d = SETUP;
               act_d   = acc;
               wr_d    = acc & we;
               for (int p = 0; p < 3; p++) begin
                  sel_d[p] = '0;
                  dbl_d[p] = '0;
                  if (acc[p]) sel_d[p][addr[p]] = 1'b1;
                  if (acc[p] && we[p]) dbl_d[p] = wdata[p];
               end
            end
         end
         SETUP: begin
            state_d  = STROBE;
            pw_d     = act_q & wr_q;
            rvalid_d = act_q & ~wr_q;
            for (int p = 0; p < 3; p++)
               if (act_q[p] && !wr_q[p]) rdata_d[p] = dbl_read[p];
         end
         STROBE: state_d = RELEASE;
         RELEASE: begin
            state_d = IDLE;
            act_d   = '0;
            wr_d    = '0;
            for (int p = 0; p < 3; p++) begin
               sel_d[p] = '0;
               dbl_d[p] = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         act_q    <= '0;
         wr_q     <= '0;
         pw_q     <= '0;
         rvalid_q <= '0;
         for (int p = 0; p < 3; p++) begin
            sel_q[p]   <= '0;
            dbl_q[p]   <= '0;
            rdata_q[p] <= '0;
         end
      end else begin
         state_q  <= state_d;
         act_q    <= act_d;
         wr_q     <= wr_d;
         pw_q     <= pw_d;
         rvalid_q <= rvalid_d;
         for (int p = 0; p < 3; p++) begin
            sel_q[p]   <= sel_d[p];
            dbl_q[p]   <= dbl_d[p];
            rdata_q[p] <= rdata_d[p];
         end
      end
   end

   assign L_gnt    = (state_q == IDLE) && acc[0];
   assign M_gnt    = (state_q == IDLE) && acc[1];
   assign R_gnt    = (state_q == IDLE) && acc[2];
   assign L_rvalid = rvalid_q[0];
   assign M_rvalid = rvalid_q[1];
   assign R_rvalid = rvalid_q[2];
   assign L_rdata  = rdata_q[0];
   assign M_rdata  = rdata_q[1];
   assign R_rdata  = rdata_q[2];
   assign LS       = sel_q[0];
   assign MS       = sel_q[1];
   assign RS       = sel_q[2];
   assign LW       = pw_q[0];
   assign MW       = pw_q[1];
   assign RW       = pw_q[2];
   assign LDBL     = dbl_q[0];
   assign MDBL     = dbl_q[1];
   assign RDBL     = dbl_q[2];

endmodule

// File: tb/tb_tri_port_ram_ctrl.sv
// Bench for tri_port_ram_ctrl: behavioural bit-cell array, a cycle-level reference
// model of grants and pass timing, directed vectors and randomized traffic.
module tb_tri_port_ram_ctrl;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int WORDS  = 16;

   typedef struct {
      int         port;
      bit         wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [2:0]       req = '0, we = '0;
   logic [3:0]       addr   [3] = '{default: 4'h0};
   logic [7:0]       wdata  [3] = '{default: 8'h00};
   logic [2:0]       gnt, rvalid, pw;
   logic [7:0]       rdata  [3];
   logic [15:0]      sel    [3];
   logic [7:0]       dbl    [3];
   logic [7:0]       dbl_rd [3];
   logic [7:0]       cells  [WORDS] = '{default: 8'h00};

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   int         busy;
   int         pass_left [3];
   bit         m_we      [3];
   logic [3:0] m_addr    [3];
   logic [7:0] m_wdata   [3];
   logic [7:0] m_rd      [3];
   logic [7:0] ref_mem   [WORDS];

   tri_port_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .L_req(req[0]), .L_we(we[0]), .L_addr(addr[0]), .L_wdata(wdata[0]),
      .L_gnt(gnt[0]), .L_rvalid(rvalid[0]), .L_rdata(rdata[0]),
      .LS(sel[0]), .LW(pw[0]), .LDBL(dbl[0]), .LDBL_read(dbl_rd[0]),
      .M_req(req[1]), .M_we(we[1]), .M_addr(addr[1]), .M_wdata(wdata[1]),
      .M_gnt(gnt[1]), .M_rvalid(rvalid[1]), .M_rdata(rdata[1]),
      .MS(sel[1]), .MW(pw[1]), .MDBL(dbl[1]), .MDBL_read(dbl_rd[1]),
      .R_req(req[2]), .R_we(we[2]), .R_addr(addr[2]), .R_wdata(wdata[2]),
      .R_gnt(gnt[2]), .R_rvalid(rvalid[2]), .R_rdata(rdata[2]),
      .RS(sel[2]), .RW(pw[2]), .RDBL(dbl[2]), .RDBL_read(dbl_rd[2])
   );

   always #5 clk = ~clk;

   // The external array: cells are written while a strobe is high, read lines follow the select.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         dbl_rd[p] = '0;
         for (int w = 0; w < WORDS; w++)
            if (sel[p][w]) dbl_rd[p] = cells[w];
      end
   end

   always @(posedge clk) begin
      for (int p = 0; p < 3; p++)
         for (int w = 0; w < WORDS; w++)
            if (pw[p] && sel[p][w]) cells[w] <= dbl[p];
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference: a grant opens a 3-cycle pass per port (select, strobe in the middle, hold),
   // and no new grant is issued until every pass has ended.
   always @(negedge clk) begin
      if (!mon_en || !rst_n) begin
         busy = 0;
         for (int p = 0; p < 3; p++) pass_left[p] = 0;
         for (int w = 0; w < WORDS; w++) ref_mem[w] = cells[w];
      end else begin
         logic [2:0] exp_gnt;
         for (int p = 0; p < 3; p++) begin
            logic [15:0] exp_sel;
            exp_sel = (pass_left[p] > 0) ? (16'd1 << m_addr[p]) : 16'd0;
            check_output($sformatf("sel_p%0d", p), sel[p], exp_sel);
            check_output($sformatf("strobe_p%0d", p), pw[p], (pass_left[p] == 2) && m_we[p]);
            check_output($sformatf("rvalid_p%0d", p), rvalid[p], (pass_left[p] == 2) && !m_we[p]);
            if (pass_left[p] == 2 && !m_we[p])
               check_output($sformatf("rdata_p%0d", p), rdata[p], m_rd[p]);
            if (pass_left[p] > 0 && m_we[p])
               check_output($sformatf("dbl_p%0d", p), dbl[p], m_wdata[p]);
            if (pass_left[p] == 0)
               check_output($sformatf("dbl_idle_p%0d", p), dbl[p], 8'h00);
            check_output($sformatf("sel_onehot_p%0d", p), $countones(sel[p]) <= 1, 1'b1);
            check_output($sformatf("strobe_has_sel_p%0d", p), !pw[p] || (sel[p] != 0), 1'b1);
            if (pass_left[p] > 0) pass_left[p]--;
         end
         exp_gnt = '0;
         if (busy == 0) begin
            for (int p = 0; p < 3; p++) begin
               bit ok;
               ok = req[p];
               for (int q = 0; q < p; q++)
                  if (req[q] && we[q] && we[p] && addr[q] == addr[p]) ok = 1'b0;
               exp_gnt[p] = ok;
            end
         end
         check_output("gnt", gnt, exp_gnt);
         if (exp_gnt != 0) begin
            busy = 3;
            for (int p = 0; p < 3; p++)
               if (exp_gnt[p]) begin
                  pass_left[p] = 3;
                  m_we[p]      = we[p];
                  m_addr[p]    = addr[p];
                  m_wdata[p]   = wdata[p];
                  m_rd[p]      = ref_mem[addr[p]];
               end
            for (int p = 0; p < 3; p++)
               if (exp_gnt[p] && we[p]) ref_mem[addr[p]] = wdata[p];
         end else if (busy > 0) begin
            busy--;
         end
      end
   end

   task automatic wait_gnt(input int p, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!gnt[p] && n < 20);
      check_output($sformatf("gnt_wait_p%0d", p), gnt[p], 1'b1);
   endtask

   // Called just after a rising edge with the controller idle; returns there 4 cycles after the grant.
   task automatic apply_stimulus(input int p, input bit w, input logic [3:0] a,
                                 input logic [7:0] d, input logic [7:0] exp_rd, output int waited);
      int n;
      req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
      wait_gnt(p, n);
      waited = n - 1;
      @(posedge clk); #1;
      req[p] = 1'b0; addr[p] = 4'($urandom); wdata[p] = 8'($urandom);
      @(negedge clk);
      @(negedge clk);
      if (!w) begin
         check_output($sformatf("vec_rvalid_p%0d", p), rvalid[p], 1'b1);
         check_output($sformatf("vec_rdata_p%0d", p), rdata[p], exp_rd);
      end else begin
         check_output($sformatf("vec_strobe_p%0d", p), pw[p], 1'b1);
      end
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t vecs [9];
      int   n;
      int   activity;
      logic [2:0] g;

      vecs[0] = '{0, 1'b1, 4'd3,  8'hA5, 8'h00};
      vecs[1] = '{0, 1'b0, 4'd3,  8'h00, 8'hA5};
      vecs[2] = '{1, 1'b1, 4'd0,  8'h3C, 8'h00};
      vecs[3] = '{2, 1'b0, 4'd0,  8'h00, 8'h3C};
      vecs[4] = '{2, 1'b1, 4'd15, 8'h5A, 8'h00};
      vecs[5] = '{1, 1'b0, 4'd15, 8'h00, 8'h5A};
      vecs[6] = '{2, 1'b1, 4'd3,  8'h00, 8'h00};
      vecs[7] = '{0, 1'b0, 4'd3,  8'h00, 8'h00};
      vecs[8] = '{1, 1'b0, 4'd15, 8'h00, 8'h5A};

      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_gnt", gnt, 3'b000);
      check_output("reset_rvalid", rvalid, 3'b000);
      check_output("reset_strobe", pw, 3'b000);
      for (int p = 0; p < 3; p++) begin
         check_output($sformatf("reset_sel_p%0d", p), sel[p], 16'h0000);
         check_output($sformatf("reset_dbl_p%0d", p), dbl[p], 8'h00);
         check_output($sformatf("reset_rdata_p%0d", p), rdata[p], 8'h00);
      end
      @(negedge clk); #2;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         apply_stimulus(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, n);

      // Triple write collision on word 5: L, then M, then R, one pass apart.
      req = 3'b111; we = 3'b111;
      addr[0] = 4'd5; addr[1] = 4'd5; addr[2] = 4'd5;
      wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
      wait_gnt(0, n);
      check_output("collide_first", gnt, 3'b001);
      @(posedge clk); #1 req[0] = 1'b0;
      wait_gnt(1, n);
      check_output("collide_second", gnt, 3'b010);
      check_output("collide_second_gap", n, 4);
      @(posedge clk); #1 req[1] = 1'b0;
      wait_gnt(2, n);
      check_output("collide_third", gnt, 3'b100);
      check_output("collide_third_gap", n, 4);
      @(posedge clk); #1 req[2] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      apply_stimulus(0, 1'b0, 4'd5, 8'h00, 8'h33, n);

      // Read during write on word 7 returns the old contents.
      apply_stimulus(1, 1'b1, 4'd7, 8'h0F, 8'h00, n);
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'd7; wdata[1] = 8'hF0;
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = 4'd7;
      wait_gnt(1, n);
      check_output("rdw_gnt", gnt, 3'b110);
      @(posedge clk); #1 req = 3'b000;
      @(negedge clk);
      @(negedge clk);
      check_output("rdw_rvalid", rvalid[2], 1'b1);
      check_output("rdw_old_data", rdata[2], 8'h0F);
      repeat (2) @(posedge clk);
      #1;
      apply_stimulus(0, 1'b0, 4'd7, 8'h00, 8'hF0, n);

      // Three concurrent reads of words 0, 1, 2.
      apply_stimulus(0, 1'b1, 4'd1, 8'h77, 8'h00, n);
      apply_stimulus(0, 1'b1, 4'd2, 8'h99, 8'h00, n);
      req = 3'b111; we = 3'b000;
      addr[0] = 4'd0; addr[1] = 4'd1; addr[2] = 4'd2;
      wait_gnt(0, n);
      check_output("triread_gnt", gnt, 3'b111);
      @(posedge clk); #1 req = 3'b000;
      @(negedge clk);
      @(negedge clk);
      check_output("triread_rvalid", rvalid, 3'b111);
      check_output("triread_l", rdata[0], 8'h3C);
      check_output("triread_m", rdata[1], 8'h77);
      check_output("triread_r", rdata[2], 8'h99);
      repeat (2) @(posedge clk);
      #1;

      // Reset during the strobe of an L write to word 9 aborts it.
      apply_stimulus(0, 1'b1, 4'd9, 8'h42, 8'h00, n);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd9; wdata[0] = 8'hE7;
      wait_gnt(0, n);
      @(posedge clk); #1 req[0] = 1'b0;
      @(posedge clk); #2;
      check_output("abort_strobe_high", pw[0], 1'b1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check_output("abort_strobe_low", pw, 3'b000);
      check_output("abort_rvalid", rvalid, 3'b000);
      check_output("abort_gnt", gnt, 3'b000);
      for (int p = 0; p < 3; p++) begin
         check_output($sformatf("abort_sel_p%0d", p), sel[p], 16'h0000);
         check_output($sformatf("abort_dbl_p%0d", p), dbl[p], 8'h00);
         check_output($sformatf("abort_rdata_p%0d", p), rdata[p], 8'h00);
      end
      repeat (2) @(posedge clk);
      #1;
      check_output("abort_hold_rvalid", rvalid, 3'b000);
      @(negedge clk); #2;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      apply_stimulus(0, 1'b0, 4'd9, 8'h00, 8'h42, n);
      check_output("post_reset_idle_grant_delay", n, 0);

      // Twenty idle cycles with no requests.
      activity = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (gnt != 0 || rvalid != 0 || pw != 0) activity++;
         for (int p = 0; p < 3; p++)
            if (sel[p] != 0 || dbl[p] != 0) activity++;
      end
      check_output("idle_activity", activity, 0);
      @(posedge clk); #1;

      // Randomized traffic on a few words to force collisions; requests hold until granted.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         g = gnt;
         @(posedge clk); #1;
         for (int p = 0; p < 3; p++)
            if (!req[p] || g[p]) begin
               req[p]   = 1'($urandom_range(0, 1));
               we[p]    = 1'($urandom_range(0, 1));
               addr[p]  = 4'($urandom_range(0, 3));
               wdata[p] = 8'($urandom);
            end
      end
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++)
         if (g[p]) req[p] = 1'b0;
      for (int c = 0; c < 12 && req != 0; c++) begin
         @(negedge clk);
         g = gnt;
         @(posedge clk); #1;
         req = req & ~g;
      end
      check_output("drain_requests", req, 3'b000);
      req = 3'b000;
      repeat (6) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
